// File: rtl/key_ctrl_led.sv
// Three-key LED controller: 2-FF sync, per-key debounce, press-edge extract, LED state register.
// Optional blink output on lit state when KEY_LED_BLINK_EN is defined.
module key_ctrl_led #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned BLINK_HALF_CYCLES = 12_500_000
) (
    input  logic m_clk,
    input  logic m_rst,
    input  logic m_key1,
    input  logic m_key2,
    input  logic m_key3,
    output logic m_led
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || BLINK_HALF_CYCLES < 1) begin : g_bad_param
        $error("key_ctrl_led: illegal parameter value");
    end

    logic [2:0] key_raw;
    logic [2:0] press;

    assign key_raw = {m_key3, m_key2, m_key1};

    for (genvar gi = 0; gi < 3; gi++) begin : g_key
        logic          sync1_q, sync1_d;
        logic          sync2_q, sync2_d;
        logic          deb_q, deb_d;
        logic          deb_dly_q, deb_dly_d;
        logic [CW-1:0] cnt_q, cnt_d;

        always_comb begin
            sync1_d   = key_raw[gi];
            sync2_d   = sync1_q;
            deb_dly_d = deb_q;
            deb_d     = deb_q;
            cnt_d     = '0;
            // Count only while the synced level disagrees; any agreement restarts the count.
            if (sync2_q != deb_q) begin
                if (cnt_q == CNT_MAX) begin
                    deb_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge m_clk) begin
            if (m_rst) begin
                sync1_q   <= 1'b1;
                sync2_q   <= 1'b1;
                deb_q     <= 1'b1;
                deb_dly_q <= 1'b1;
                cnt_q     <= '0;
            end else begin
                sync1_q   <= sync1_d;
                sync2_q   <= sync2_d;
                deb_q     <= deb_d;
                deb_dly_q <= deb_dly_d;
                cnt_q     <= cnt_d;
            end
        end

        // Falling edge of the debounced level only; release is ignored.
        assign press[gi] = deb_dly_q & ~deb_q;
    end

    logic led_state_q, led_state_d;
    logic m_led_q, m_led_d;

    always_comb begin
        led_state_d = led_state_q;
        if (press[2]) begin
            led_state_d = 1'b0;
        end else if (press[1]) begin
            led_state_d = 1'b1;
        end else if (press[0]) begin
            led_state_d = ~led_state_q;
        end
    end

    always_ff @(posedge m_clk) begin
        if (m_rst) begin
            led_state_q <= 1'b0;
        end else begin
            led_state_q <= led_state_d;
        end
    end

`ifdef KEY_LED_BLINK_EN
    localparam int BW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF_CYCLES - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (led_state_q) begin
            if (blink_cnt_q == BLINK_MAX) begin
                phase_d = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                phase_d     = phase_q;
            end
        end
        // Phase 0 is the lit half, so each lit period opens with the LED on.
        m_led_d = led_state_q & ~phase_q;
    end

    always_ff @(posedge m_clk) begin
        if (m_rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`else
    always_comb begin
        m_led_d = led_state_q;
    end
`endif

    always_ff @(posedge m_clk) begin
        if (m_rst) begin
            m_led_q <= 1'b0;
        end else begin
            m_led_q <= m_led_d;
        end
    end

    assign m_led = m_led_q;

endmodule

// File: tb/tb_key_ctrl_led.sv
// Self-checking bench for key_ctrl_led with DEBOUNCE_CYCLES=4, BLINK_HALF_CYCLES=3.
// Inputs change on the falling edge; expected LED values go through a queue and are checked on the falling edge.
module tb_key_ctrl_led;

    logic m_clk = 1'b0;
    logic m_rst;
    logic m_key1, m_key2, m_key3;
    logic m_led;

    int errors = 0;
    int checks = 0;
    logic exp_q[$];

    key_ctrl_led #(
        .DEBOUNCE_CYCLES  (4),
        .BLINK_HALF_CYCLES(3)
    ) dut (
        .m_clk (m_clk),
        .m_rst (m_rst),
        .m_key1(m_key1),
        .m_key2(m_key2),
        .m_key3(m_key3),
        .m_led (m_led)
    );

    always #5 m_clk = ~m_clk;

    typedef struct {
        logic  k1;
        logic  k2;
        logic  k3;
        int    low_cycles;
        logic  exp_led;
        string name;
    } vec_t;

    vec_t vecs[9];

    // Push the expected value, wait for the next sample point, pop and compare.
    task automatic cycle_chk(input logic exp, input string name);
        logic e;
        exp_q.push_back(exp);
        @(negedge m_clk);
        e = exp_q.pop_front();
        checks++;
        if (m_led !== e) begin
            errors++;
            $display("FAIL %s: m_led=%b expected=%b at %0t", name, m_led, e, $time);
        end else begin
            $display("ok   %s: m_led=%b at %0t", name, m_led, $time);
        end
    endtask

    task automatic keys(input logic k1, input logic k2, input logic k3);
        m_key1 = k1;
        m_key2 = k2;
        m_key3 = k3;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge m_clk);
    endtask

    initial begin
        m_rst = 1'b1;
        keys(1'b1, 1'b1, 1'b1);

        // Reset with random key activity, then idle.
        for (int i = 0; i < 3; i++) begin
            keys(1'($urandom), 1'($urandom), 1'($urandom));
            cycle_chk(1'b0, "reset_hold");
        end
        m_rst = 1'b0;
        keys(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle_chk(1'b0, "post_reset_idle");

`ifdef KEY_LED_BLINK_EN
        keys(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cycle_chk(1'b0, "blink_latency");
        for (int i = 0; i < 12; i++) begin
            if (i == 3) keys(1'b1, 1'b1, 1'b1);
            cycle_chk(((i / 3) % 2) == 0, "blink_pattern");
        end
        keys(1'b1, 1'b1, 1'b0);
        wait_cycles(7);
        keys(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle_chk(1'b0, "blink_clear_steady");
`else
        // Exact latency: first low sampled at edge N, LED changes at N+7.
        keys(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) cycle_chk(1'b0, "latency_pre");
        cycle_chk(1'b1, "latency_edge");
        wait_cycles(2);
        keys(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cycle_chk(1'b1, "release_no_change");

        vecs[0] = '{1'b0, 1'b1, 1'b1, 10, 1'b0, "k1_toggle_off"};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 10, 1'b0, "k3_clear_when_0"};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 10, 1'b1, "k2_set"};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 10, 1'b1, "k2_set_again"};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 10, 1'b0, "k3_clear"};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 10, 1'b1, "k1_toggle_on"};
        vecs[6] = '{1'b0, 1'b0, 1'b1,  3, 1'b1, "short_glitch_k1k2"};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 10, 1'b1, "k2_beats_k1"};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 10, 1'b0, "k3_beats_k2"};
        for (int v = 0; v < 9; v++) begin
            keys(vecs[v].k1, vecs[v].k2, vecs[v].k3);
            wait_cycles(vecs[v].low_cycles);
            keys(1'b1, 1'b1, 1'b1);
            wait_cycles(9);
            cycle_chk(vecs[v].exp_led, vecs[v].name);
        end

        // Bouncing key1 never accepted; the following stable low toggles once.
        for (int b = 0; b < 5; b++) begin
            keys(1'b0, 1'b1, 1'b1);
            cycle_chk(1'b0, "bounce_low");
            cycle_chk(1'b0, "bounce_low");
            keys(1'b1, 1'b1, 1'b1);
            cycle_chk(1'b0, "bounce_high");
        end
        keys(1'b0, 1'b1, 1'b1);
        wait_cycles(10);
        keys(1'b1, 1'b1, 1'b1);
        wait_cycles(9);
        cycle_chk(1'b1, "bounce_one_toggle");

        // All three together: clear wins, no toggle afterwards.
        keys(1'b0, 1'b0, 1'b0);
        wait_cycles(10);
        keys(1'b1, 1'b1, 1'b1);
        wait_cycles(8);
        for (int i = 0; i < 6; i++) cycle_chk(1'b0, "all_keys_clear");

        // Key held low through reset: partial count discarded, accepted after full latency.
        keys(1'b1, 1'b0, 1'b1);
        wait_cycles(10);
        keys(1'b1, 1'b1, 1'b1);
        wait_cycles(9);
        cycle_chk(1'b1, "pre_reset_set");
        keys(1'b0, 1'b1, 1'b1);
        wait_cycles(4);
        m_rst = 1'b1;
        cycle_chk(1'b0, "mid_debounce_reset");
        cycle_chk(1'b0, "mid_debounce_reset");
        m_rst = 1'b0;
        for (int i = 0; i < 7; i++) cycle_chk(1'b0, "held_through_reset_pre");
        cycle_chk(1'b1, "held_through_reset_edge");
        keys(1'b1, 1'b1, 1'b1);
        wait_cycles(9);
        cycle_chk(1'b1, "held_through_reset_final");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
